// File: rtl/spi_register_master_if.sv
// Request/sample bus between a host controller and spi_register_master.
interface spi_register_master_if;
  localparam int unsigned NUM_W = 15;
  localparam int unsigned VAL_W = 16;

  logic             i_ReqValid;
  logic             o_ReqReady;
  logic             i_ReqWrite;
  logic [NUM_W-1:0] i_ReqNumber;
  logic [VAL_W-1:0] i_ReqValue;
  logic             o_SampleValid;
  logic [VAL_W-1:0] o_Sample;
  logic             o_Busy;

  // Host side: issues requests, consumes samples.
  modport master (
    output i_ReqValid, i_ReqWrite, i_ReqNumber, i_ReqValue,
    input  o_ReqReady, o_SampleValid, o_Sample, o_Busy
  );

  // SPI master side: accepts requests, reports samples.
  modport slave (
    input  i_ReqValid, i_ReqWrite, i_ReqNumber, i_ReqValue,
    output o_ReqReady, o_SampleValid, o_Sample, o_Busy
  );
endinterface

// File: rtl/spi_register_master.sv
// SPI initiator: serializes register writes / sample polls as 32-bit mode-0
// frames (MSB first) and captures the 16-bit sample returned on MISO.
module spi_register_master #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned GAP_CYCLES = 8
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  spi_register_master_if.slave  bus,
  output logic                  o_SPI_SCK,
  output logic                  o_SPI_MOSI,
  input  logic                  i_SPI_MISO
);

  localparam int unsigned FRAME_W = 32;
  localparam int unsigned SAMP_W  = 16;
  localparam int unsigned BIT_W   = 5;
  localparam int unsigned CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] PH_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_LOW   = 3'd2;
  localparam logic [2:0] S_HIGH  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]         state_q,  state_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [BIT_W-1:0]   bit_q,    bit_d;
  logic [FRAME_W-1:0] shreg_q,  shreg_d;
  logic [SAMP_W-1:0]  rx_q,     rx_d;
  logic [SAMP_W-1:0]  sample_q, sample_d;
  logic               sample_valid_q, sample_valid_d;
  logic               sck_q,    sck_d;
  logic               mosi_q,   mosi_d;
  logic               ready_q,  ready_d;
  logic               busy_q,   busy_d;
  logic               miso_s1_q, miso_s2_q;

  // State, datapath and MISO synchronizer registers.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      bit_q          <= '0;
      shreg_q        <= '0;
      rx_q           <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      sck_q          <= 1'b0;
      mosi_q         <= 1'b0;
      ready_q        <= 1'b1;
      busy_q         <= 1'b0;
      miso_s1_q      <= 1'b0;
      miso_s2_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      bit_q          <= bit_d;
      shreg_q        <= shreg_d;
      rx_q           <= rx_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      sck_q          <= sck_d;
      mosi_q         <= mosi_d;
      ready_q        <= ready_d;
      busy_q         <= busy_d;
      miso_s1_q      <= i_SPI_MISO;
      miso_s2_q      <= miso_s1_q;
    end
  end

  // Next-state and registered-output logic for the frame sequencer.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    bit_d          = bit_q;
    shreg_d        = shreg_q;
    rx_d           = rx_q;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
    sck_d          = sck_q;
    mosi_d         = mosi_q;
    ready_d        = ready_q;
    busy_d         = busy_q;

    case (state_q)
      S_IDLE: begin
        if (bus.i_ReqValid && ready_q) begin
          state_d = S_START;
          shreg_d = {bus.i_ReqWrite, bus.i_ReqNumber,
                     bus.i_ReqWrite ? bus.i_ReqValue : SAMP_W'(0)};
          bit_d   = BIT_W'(FRAME_W - 1);
          cnt_d   = '0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end

      // One setup cycle after accept, then bit 31 goes out on MOSI.
      S_START: begin
        state_d = S_LOW;
        cnt_d   = '0;
        sck_d   = 1'b0;
        mosi_d  = shreg_q[FRAME_W-1];
      end

      S_LOW: begin
        if (cnt_q == PH_LAST) begin
          cnt_d   = '0;
          state_d = S_HIGH;
          sck_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Last cycle of HIGH: sample MISO for the upper 16 bits, then advance.
      S_HIGH: begin
        if (cnt_q == PH_LAST) begin
          cnt_d = '0;
          sck_d = 1'b0;
          if (bit_q >= BIT_W'(SAMP_W)) begin
            rx_d = {rx_q[SAMP_W-2:0], miso_s2_q};
          end
          if (bit_q == '0) begin
            state_d        = S_GAP;
            mosi_d         = 1'b0;
            sample_d       = rx_q;
            sample_valid_d = 1'b1;
          end else begin
            state_d = S_LOW;
            bit_d   = bit_q - BIT_W'(1);
            shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
            mosi_d  = shreg_q[FRAME_W-2];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        sck_d   = 1'b0;
        mosi_d  = 1'b0;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign o_SPI_SCK         = sck_q;
  assign o_SPI_MOSI        = mosi_q;
  assign bus.o_ReqReady    = ready_q;
  assign bus.o_Busy        = busy_q;
  assign bus.o_SampleValid = sample_valid_q;
  assign bus.o_Sample      = sample_q;

endmodule
